// File: rtl/reg_sched_pkg.sv
// Shared types and constants for the register-file issue/writeback scheduler.
//   lane_req_t : one issue-group slot (valid, writes-dest, rd, rs, rt)
//   wb_req_t   : one writeback slot (valid, rd, data)
package reg_sched_pkg;

  localparam int unsigned NLANE  = 3;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;
  localparam int unsigned DW     = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } lane_req_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DW-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_sched_lane_hazard.sv
// Combinational hazard detect for one issue lane.
//   busy        : pending-write scoreboard
//   req         : this lane's request
//   prev_valid  : valid bits of up to two earlier lanes (tie to 0 when absent)
//   prev_wr     : write-dest bits of the earlier lanes
//   prev_rd     : destination registers of the earlier lanes
//   hazard      : lane must not issue this cycle
module lane_hazard
  import reg_sched_pkg::*;
(
  input  logic [NREG-1:0]                  busy,
  input  lane_req_t                        req,
  input  logic [NLANE-2:0]                 prev_valid,
  input  logic [NLANE-2:0]                 prev_wr,
  input  logic [NLANE-2:0][REG_AW-1:0]     prev_rd,
  output logic                             hazard
);

  logic raw;
  logic waw;
  logic intra;

  always_comb begin
    raw   = ((req.rs != ZERO_REG) && busy[req.rs]) ||
            ((req.rt != ZERO_REG) && busy[req.rt]);
    waw   = req.wr && (req.rd != ZERO_REG) && busy[req.rd];
    intra = 1'b0;
    for (int unsigned j = 0; j < NLANE - 1; j++) begin
      if (prev_valid[j] && prev_wr[j] && (prev_rd[j] != ZERO_REG)) begin
        if ((prev_rd[j] == req.rs) || (prev_rd[j] == req.rt) ||
            (req.wr && (prev_rd[j] == req.rd)))
          intra = 1'b1;
      end
    end
    hazard = req.valid && (raw || waw || intra);
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Issue/writeback scheduler for the 3-write/6-read shared register file.
//   iss_*        : 3-lane issue group; iss_grant is the accepted in-order prefix
//   wb_*         : per-lane writeback requests, registered onto we/rw/inW
//   we/rw/inW    : register-file write ports (one cycle after wb_valid)
//   busy         : pending-write scoreboard, bit 0 always 0
//   wb_err       : sticky flag for same-register writeback collisions
module reg_wb_sched
  import reg_sched_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      iss_valid,
  input  logic [2:0]      iss_wr,
  input  logic [AW-1:0]   iss_rd1,
  input  logic [AW-1:0]   iss_rd2,
  input  logic [AW-1:0]   iss_rd3,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rs3,
  input  logic [AW-1:0]   iss_rt1,
  input  logic [AW-1:0]   iss_rt2,
  input  logic [AW-1:0]   iss_rt3,
  output logic [2:0]      iss_grant,
  input  logic [2:0]      wb_valid,
  input  logic [AW-1:0]   wb_rd1,
  input  logic [AW-1:0]   wb_rd2,
  input  logic [AW-1:0]   wb_rd3,
  input  logic [DW-1:0]   wb_data1,
  input  logic [DW-1:0]   wb_data2,
  input  logic [DW-1:0]   wb_data3,
  output logic            we1,
  output logic            we2,
  output logic            we3,
  output logic [AW-1:0]   rw1,
  output logic [AW-1:0]   rw2,
  output logic [AW-1:0]   rw3,
  output logic [DW-1:0]   inW1,
  output logic [DW-1:0]   inW2,
  output logic [DW-1:0]   inW3,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);

  lane_req_t            req [NLANE];
  wb_req_t              wb  [NLANE];
  logic [NLANE-1:0]     haz;
  logic [NLANE-1:0]     wb_keep;
  logic                 wb_collide;
  logic [NREG-1:0]      busy_set;
  logic [NREG-1:0]      busy_clr;

  logic [NLANE-1:0]     we_q;
  logic [AW-1:0]        rw_q  [NLANE];
  logic [DW-1:0]        inw_q [NLANE];
  logic [NREG-1:0]      busy_q;
  logic                 err_q;

  always_comb begin
    req[0] = '{valid: iss_valid[0], wr: iss_wr[0], rd: iss_rd1, rs: iss_rs1, rt: iss_rt1};
    req[1] = '{valid: iss_valid[1], wr: iss_wr[1], rd: iss_rd2, rs: iss_rs2, rt: iss_rt2};
    req[2] = '{valid: iss_valid[2], wr: iss_wr[2], rd: iss_rd3, rs: iss_rs3, rt: iss_rt3};
    wb[0]  = '{valid: wb_valid[0], rd: wb_rd1, data: wb_data1};
    wb[1]  = '{valid: wb_valid[1], rd: wb_rd2, data: wb_data2};
    wb[2]  = '{valid: wb_valid[2], rd: wb_rd3, data: wb_data3};
  end

  lane_hazard u_haz0 (
    .busy       (busy_q),
    .req        (req[0]),
    .prev_valid ('0),
    .prev_wr    ('0),
    .prev_rd    ('0),
    .hazard     (haz[0])
  );

  lane_hazard u_haz1 (
    .busy       (busy_q),
    .req        (req[1]),
    .prev_valid ({1'b0, req[0].valid}),
    .prev_wr    ({1'b0, req[0].wr}),
    .prev_rd    ({ZERO_REG, req[0].rd}),
    .hazard     (haz[1])
  );

  lane_hazard u_haz2 (
    .busy       (busy_q),
    .req        (req[2]),
    .prev_valid ({req[1].valid, req[0].valid}),
    .prev_wr    ({req[1].wr, req[0].wr}),
    .prev_rd    ({req[1].rd, req[0].rd}),
    .hazard     (haz[2])
  );

  // In-order prefix: a valid lane that is not granted blocks every later
  // lane; an invalid lane is transparent.
  always_comb begin
    logic blocked;
    iss_grant = '0;
    blocked   = reset;
    for (int unsigned k = 0; k < NLANE; k++) begin
      iss_grant[k] = req[k].valid && !haz[k] && !blocked;
      if (req[k].valid && !iss_grant[k])
        blocked = 1'b1;
    end
  end

  // Youngest lane wins a same-register collision; older duplicates are
  // dropped and the event is flagged.
  always_comb begin
    wb_keep    = '0;
    wb_collide = 1'b0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      logic shadowed;
      shadowed = 1'b0;
      for (int unsigned j = k + 1; j < NLANE; j++) begin
        if (wb[j].valid && (wb[j].rd == wb[k].rd))
          shadowed = 1'b1;
      end
      wb_keep[k] = wb[k].valid && (wb[k].rd != ZERO_REG) && !shadowed;
      if (wb[k].valid && (wb[k].rd != ZERO_REG) && shadowed)
        wb_collide = 1'b1;
    end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      if (iss_grant[k] && req[k].wr)
        busy_set[req[k].rd] = 1'b1;
      if (we_q[k])
        busy_clr[rw_q[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      we_q   <= '0;
      err_q  <= 1'b0;
      for (int unsigned k = 0; k < NLANE; k++) begin
        rw_q[k]  <= '0;
        inw_q[k] <= '0;
      end
    end else begin
      // set after clear so a coincident issue keeps the register busy
      busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~{{(NREG-1){1'b0}}, 1'b1};
      err_q  <= err_q | wb_collide;
      for (int unsigned k = 0; k < NLANE; k++) begin
        we_q[k] <= wb_keep[k];
        if (wb[k].valid) begin
          rw_q[k]  <= wb[k].rd;
          inw_q[k] <= wb[k].data;
        end
      end
    end
  end

  assign busy   = busy_q;
  assign wb_err = err_q;
  assign we1    = we_q[0];
  assign we2    = we_q[1];
  assign we3    = we_q[2];
  assign rw1    = rw_q[0];
  assign rw2    = rw_q[1];
  assign rw3    = rw_q[2];
  assign inW1   = inw_q[0];
  assign inW2   = inw_q[1];
  assign inW3   = inw_q[2];

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched with hand-computed expected values.
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  iss_valid, iss_wr, iss_grant, wb_valid;
  logic [4:0]  iss_rd1, iss_rd2, iss_rd3, iss_rs1, iss_rs2, iss_rs3;
  logic [4:0]  iss_rt1, iss_rt2, iss_rt3, wb_rd1, wb_rd2, wb_rd3;
  logic [31:0] wb_data1, wb_data2, wb_data3;
  logic        we1, we2, we3, wb_err;
  logic [4:0]  rw1, rw2, rw3;
  logic [31:0] inW1, inW2, inW3, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_busy;

  reg_wb_sched #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_wr(iss_wr),
    .iss_rd1(iss_rd1), .iss_rd2(iss_rd2), .iss_rd3(iss_rd3),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs3(iss_rs3),
    .iss_rt1(iss_rt1), .iss_rt2(iss_rt2), .iss_rt3(iss_rt3),
    .iss_grant(iss_grant),
    .wb_valid(wb_valid),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2), .wb_rd3(wb_rd3),
    .wb_data1(wb_data1), .wb_data2(wb_data2), .wb_data3(wb_data3),
    .we1(we1), .we2(we2), .we3(we3),
    .rw1(rw1), .rw2(rw2), .rw3(rw3),
    .inW1(inW1), .inW2(inW2), .inW3(inW3),
    .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_iss();
    iss_valid = '0; iss_wr = '0;
    iss_rd1 = '0; iss_rd2 = '0; iss_rd3 = '0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rs3 = '0;
    iss_rt1 = '0; iss_rt2 = '0; iss_rt3 = '0;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
    wb_rd1 = '0; wb_rd2 = '0; wb_rd3 = '0;
    wb_data1 = '0; wb_data2 = '0; wb_data3 = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_iss();
    clear_wb();
    step();
    step();

    // reset state
    check("rst_busy", busy, 32'h0);
    check("rst_we", {29'd0, we3, we2, we1}, 32'h0);
    check("rst_err", {31'd0, wb_err}, 32'h0);
    check("rst_rw1", {27'd0, rw1}, 32'h0);
    check("rst_inW1", inW1, 32'h0);
    reset = 1'b0;

    // three independent writers
    iss_valid = 3'b111; iss_wr = 3'b111;
    iss_rd1 = 5'd1; iss_rd2 = 5'd2; iss_rd3 = 5'd3;
    #1;
    check("indep_grant", {29'd0, iss_grant}, 32'h7);
    step();
    check("indep_busy", busy, 32'h0000_000E);

    // make r5 busy via lane0 alone
    clear_iss();
    iss_valid = 3'b001; iss_wr = 3'b001; iss_rd1 = 5'd5;
    #1;
    check("r5_grant", {29'd0, iss_grant}, 32'h1);
    step();
    check("r5_busy", busy, 32'h0000_002E);

    // RAW stall on r5, writeback of r5 in the same cycle
    clear_iss();
    iss_valid = 3'b011; iss_wr = 3'b010;
    iss_rs1 = 5'd5; iss_rd2 = 5'd6;
    wb_valid = 3'b001; wb_rd1 = 5'd5; wb_data1 = 32'h55;
    #1;
    check("raw_grant0", {29'd0, iss_grant}, 32'h0);
    step();
    check("wb5_we1", {31'd0, we1}, 32'h1);
    check("wb5_rw1", {27'd0, rw1}, 32'h5);
    check("wb5_inW1", inW1, 32'h55);
    check("wb5_busy_held", busy, 32'h0000_002E);
    check("raw_grant1", {29'd0, iss_grant}, 32'h0);
    clear_wb();
    step();
    check("wb5_busy_clr", busy, 32'h0000_000E);
    check("wb5_we1_off", {31'd0, we1}, 32'h0);
    check("wb5_rw1_hold", {27'd0, rw1}, 32'h5);
    check("raw_grant2", {29'd0, iss_grant}, 32'h3);
    step();
    check("r6_busy", busy, 32'h0000_004E);
    clear_iss();

    // intra-group RAW
    iss_valid = 3'b111; iss_wr = 3'b111;
    iss_rd1 = 5'd7; iss_rs2 = 5'd7; iss_rd2 = 5'd8; iss_rd3 = 5'd10;
    #1;
    check("intra_raw", {29'd0, iss_grant}, 32'h1);
    iss_valid = 3'b110;
    #1;
    check("lane0_invalid", {29'd0, iss_grant}, 32'h6);
    clear_iss();
    step();

    // WAW against the scoreboard
    iss_valid = 3'b001; iss_wr = 3'b001; iss_rd1 = 5'd1;
    #1;
    check("waw_busy", {29'd0, iss_grant}, 32'h0);
    // intra-group WAW
    iss_valid = 3'b011; iss_wr = 3'b011; iss_rd1 = 5'd11; iss_rd2 = 5'd11;
    #1;
    check("waw_intra", {29'd0, iss_grant}, 32'h1);
    // $0 destination never creates a dependency
    iss_rd1 = 5'd0; iss_rd2 = 5'd12;
    #1;
    check("zero_dep", {29'd0, iss_grant}, 32'h3);
    clear_iss();
    step();
    check("no_issue_busy", busy, 32'h0000_004E);

    // writeback to $0 on lane 2, writeback to idle r20 on lane 0
    wb_valid = 3'b101; wb_rd1 = 5'd20; wb_data1 = 32'h20;
    wb_rd3 = 5'd0; wb_data3 = 32'hDEAD_BEEF;
    step();
    check("wb0_we3", {31'd0, we3}, 32'h0);
    check("wb0_inW3", inW3, 32'hDEAD_BEEF);
    check("wb20_we1", {31'd0, we1}, 32'h1);
    check("wb20_rw1", {27'd0, rw1}, 32'd20);
    check("wb0_busy", busy, 32'h0000_004E);
    check("wb0_err", {31'd0, wb_err}, 32'h0);
    clear_wb();
    step();
    check("wb20_busy", busy, 32'h0000_004E);

    // collision lanes 1 and 3 on r9
    wb_valid = 3'b101; wb_rd1 = 5'd9; wb_data1 = 32'h11;
    wb_rd3 = 5'd9; wb_data3 = 32'h33;
    step();
    check("col_we1", {31'd0, we1}, 32'h0);
    check("col_we3", {31'd0, we3}, 32'h1);
    check("col_inW3", inW3, 32'h33);
    check("col_rw1", {27'd0, rw1}, 32'd9);
    check("col_err", {31'd0, wb_err}, 32'h1);
    clear_wb();
    step();
    check("col_err_held", {31'd0, wb_err}, 32'h1);
    check("col_we3_off", {31'd0, we3}, 32'h0);

    // fill remaining scoreboard one register at a time
    exp_busy = 32'h0000_004E;
    for (int r = 1; r < 32; r++) begin
      if (!exp_busy[r]) begin
        clear_iss();
        iss_valid = 3'b001; iss_wr = 3'b001; iss_rd1 = 5'(r);
        #1;
        check("fill_grant", {29'd0, iss_grant}, 32'h1);
        step();
        exp_busy[r] = 1'b1;
      end
    end
    clear_iss();
    check("fill_busy", busy, 32'hFFFF_FFFE);

    // reset mid-operation with writebacks pending
    reset = 1'b1;
    iss_valid = 3'b111; iss_wr = 3'b111;
    iss_rd1 = 5'd0; iss_rd2 = 5'd0; iss_rd3 = 5'd0;
    wb_valid = 3'b111; wb_rd1 = 5'd4; wb_rd2 = 5'd5; wb_rd3 = 5'd6;
    wb_data1 = 32'hA; wb_data2 = 32'hB; wb_data3 = 32'hC;
    #1;
    check("rst_grant", {29'd0, iss_grant}, 32'h0);
    step();
    check("mid_rst_busy", busy, 32'h0);
    check("mid_rst_we", {29'd0, we3, we2, we1}, 32'h0);
    check("mid_rst_err", {31'd0, wb_err}, 32'h0);
    check("mid_rst_inW2", inW2, 32'h0);
    check("mid_rst_grant", {29'd0, iss_grant}, 32'h0);
    reset = 1'b0;
    clear_iss();
    clear_wb();
    step();
    check("post_rst_busy", busy, 32'h0);
    check("post_rst_we", {29'd0, we3, we2, we1}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Issue/writeback scheduler for the 3-write-port, 6-read-port shared register file of the 3-lane superscalar core.
- Keeps a busy (pending-write) scoreboard over the 32 architectural registers.
- Grants issue to an in-order prefix of the 3-lane issue group, stalling on RAW/WAW hazards.
- Registers the three lanes' writeback requests into the register file's we/rw/inW ports, suppressing $0 writes and resolving same-register collisions.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  3  lane k holds an instruction for issue this cycle.
- iss_wr  in  3  lane k's instruction writes a destination register.
- iss_rd1/iss_rd2/iss_rd3  in  AW each  destination register per lane.
- iss_rs1/iss_rs2/iss_rs3  in  AW each  source A per lane.
- iss_rt1/iss_rt2/iss_rt3  in  AW each  source B per lane.
- iss_grant  out  3  combinational; lane k is accepted this cycle.
- wb_valid  in  3  lane k presents a writeback this cycle.
- wb_rd1/wb_rd2/wb_rd3  in  AW each  writeback destination per lane.
- wb_data1/wb_data2/wb_data3  in  DW each  writeback data per lane.
- we1/we2/we3  out  1 each  registered write enables to the register file.
- rw1/rw2/rw3  out  AW each  registered write addresses.
- inW1/inW2/inW3  out  DW each  registered write data.
- busy  out  NREG  scoreboard vector; bit 0 is always 0.
- wb_err  out  1  sticky; an illegal same-register writeback collision occurred.

Behaviour:
- Reset: busy=0, we1..3=0, rw1..3=0, inW1..3=0, wb_err=0. iss_grant=0 in any cycle where reset=1.
- Lane hazard(k) is true if iss_valid[k] and any of the following holds:
  - (a) busy[rs_k] or busy[rt_k] (RAW), with $0 never busy;
  - (b) iss_wr[k] and busy[rd_k] (WAW);
  - (c) an earlier lane j<k in the same group has iss_valid[j], iss_wr[j] and rd_j!=0, and rd_j equals rs_k, rt_k, or (when iss_wr[k]) rd_k.
- In-order prefix grant: iss_grant[k] = iss_valid[k] & ~hazard(k) & grant of every lane j<k that is valid.
  - An invalid lower lane does not block higher lanes.
  - A valid, hazarded lane blocks all higher lanes.
- Busy set: at the clock edge, each granted lane with iss_wr=1 and rd!=0 sets busy[rd].
- Writeback pipeline, 1-cycle latency: wb_valid[k] sampled at edge E gives we_k=1, rw_k=wb_rd_k, inW_k=wb_data_k for the cycle after E.
  - wb_rd_k==0 gives we_k=0; rw and inW still load.
  - Without a valid writeback, we_k=0 and rw/inW hold their values.
- Busy clear: busy[rw_k] clears at the edge ending the cycle in which we_k=1. The register file latches during that cycle, so an instruction issued in the following cycle reads the committed value. There is no bypass.
- Set/clear on the same register at the same edge: set wins. This is unreachable when sources obey WAW stalls, but it is defined.
- Writeback collision: two or more valid lanes with the same non-zero wb_rd in one cycle.
  - The highest-numbered lane (youngest) keeps we=1; the lower lanes are forced to we=0.
  - wb_err is set and held until reset.
- Writeback to a register that is not busy: performed normally, no error, and busy stays 0.
- Reset mid-operation: scoreboard and pending writes are discarded; there is no partial writeback.

Decomposition:
- Package reg_sched_pkg:
  - NLANE=3, REG_AW=5, NREG=32, DW=32, ZERO_REG=5'd0;
  - a lane-request struct {valid, wr, rd, rs, rt};
  - a writeback struct {valid, rd, data}.
- Sub-module lane_hazard: combinational hazard(k) from busy, lane k's fields, and the earlier lanes' rd/wr/valid. It is instantiated 3 times, with lane 0 having no earlier lanes.
- The top level holds the grant prefix chain, the busy register, the writeback registers, and collision/error logic.

Test Plan:
- Reset, then 3 independent lanes (rd=1,2,3; sources $0) valid → iss_grant=3'b111; next cycle busy=0x0000000E.
- With busy[5]=1, lane0 rs=5, lane1 independent → iss_grant=3'b000. Writeback rd=5 → we1=1, rw1=5 next cycle, busy[5] clears at the end of that cycle, and lane0 is granted the cycle after.
- Intra-group RAW: lane0 rd=7, lane1 rs=7, lane2 independent → iss_grant=3'b001. Lane0 invalid with lane1/lane2 independent → 3'b110.
- Writeback to $0 on lane2 with data 0xDEADBEEF → we3=0, and busy is unchanged.
- Collision: wb lanes 1 and 3 both rd=9, data 0x11/0x33 → we1=0, we3=1, inW3=0x33, wb_err=1 and held until reset.
- Reset asserted with busy=0xFFFFFFFE and writebacks pending → next cycle busy=0, we1..3=0, wb_err=0, iss_grant=0 during reset.
